mux_sel_key_ctrl: RTL and testbench
===================================

// Module: mux_sel_key_ctrl
// PURPOSE
//   Upstream control stage for mux2_1: turns a raw, bouncing push-button into a clean
//   select line. Synchronises the button, debounces press and release with a 4-state FSM,
//   and toggles sel once per confirmed press. sel drives mux2_1.sel directly;
//   key_flag is a one-cycle press strobe for other consumers.
// PARAMETERS
//   CNT_MAX         20'd999_999  debounce length: consecutive stable samples needed = CNT_MAX+1
//                                (20 ms at 50 MHz); sim uses 4
//   KEY_ACTIVE_LOW  1            1: key_in==0 means pressed; 0: key_in==1 means pressed
//   SEL_INIT        1'b0         sel value after reset
//   localparam CNT_W = $clog2(CNT_MAX+1)
// PORTS
//   sys_clk    in   1  system clock, all logic on rising edge
//   sys_rst    in   1  synchronous, active-high reset
//   key_in     in   1  raw asynchronous button level, may bounce
//   sel        out  1  registered select for mux2_1, toggles per confirmed press
//   key_flag   out  1  registered one-cycle pulse, coincident with each sel toggle
//   key_state  out  1  registered, 1 while the debounced key is held (PRESSED or REL_FILT)
// BEHAVIOUR
//   Reset (sys_rst==1 at an edge, priority over everything):
//     state=IDLE, cnt=0, sel=SEL_INIT, key_flag=0, key_state=0.
//     Both sync flops load the released level. Mid-press reset aborts the filter and emits no flag.
//   Sync: two-flop synchroniser key_in -> key_s; key_s = key_in delayed 2 edges.
//     p = key_s==pressed level. No other logic samples key_in.
//   FSM (all decisions on key_s):
//     IDLE:      p -> PRESS_FILT, cnt<=1; else stay, cnt<=0
//     PRESS_FILT: !p -> IDLE, cnt<=0 (bounce, no flag)
//                 p && cnt==CNT_MAX -> PRESSED, cnt<=0, key_flag<=1, sel<=~sel, key_state<=1
//                 p && cnt<CNT_MAX -> cnt<=cnt+1
//     PRESSED:   !p -> REL_FILT, cnt<=1; else stay
//     REL_FILT:  p -> PRESSED, cnt<=0 (release bounce ignored)
//                !p && cnt==CNT_MAX -> IDLE, cnt<=0, key_state<=0
//                else cnt<=cnt+1
//   Timing: press confirmed when key_s is pressed on CNT_MAX+1 consecutive edges.
//     Edge 0 = first edge sampling key_in pressed into flop 1.
//     key_flag and new sel are visible after edge CNT_MAX+2 relative to edge 0.
//   key_flag: exactly 1 cycle high per confirmed press; 0 in all other cycles.
//     Holding the key never re-fires.
//   sel changes only together with key_flag; otherwise it holds.
//     At most one toggle per press/release cycle.
//   cnt never exceeds CNT_MAX (no wrap); cleared on every state exit.
//   Default arcs: undefined state -> IDLE.
//   Glitch shorter than 2 cycles may still propagate through the synchroniser.
//     It is rejected by the filter unless it lasts CNT_MAX+1 samples.
// TESTING (CNT_MAX=4, KEY_ACTIVE_LOW=1, SEL_INIT=0)
//   1 Reset: sys_rst=1 for 3 cycles, key_in=1
//       -> sel=0, key_flag=0, key_state=0. Stays so 20 cycles after release of reset.
//   2 Clean press: key_in=0 held 20 cycles
//       -> key_flag=1 for exactly one cycle, after edge 6 from first low sample; sel 0->1; key_state=1.
//       Release for 20 cycles -> key_state=0 six edges after release, no flag.
//   3 Bounce: key_in low 3 cycles, high 1, low 3, high 10
//       -> no key_flag, sel unchanged, key_state=0.
//   4 Release bounce: confirmed press, then key_in high 2 cycles, low 5, high 20
//       -> one key_flag total; key_state stays 1 through the bounce.
//   5 Three full press/release cycles
//       -> sel sequence 0->1->0->1, three single-cycle flags.
//       Compare mux2_1.out against in_2/in_1 as sel changes.
//   6 Reset mid-filter: key_in=0, assert sys_rst at cnt=3, deassert with key still low
//       -> no flag from the aborted press, sel=SEL_INIT.
//       A new press confirms CNT_MAX+1 samples after reset release.

Source files
------------

// File: rtl/mux_sel_key_ctrl.sv
// Push-button front end for mux2_1: synchronises a bouncing key, debounces press and
// release, and toggles sel once per confirmed press with a one-cycle key_flag strobe.
module mux_sel_key_ctrl #(
    parameter int unsigned CNT_MAX        = 20'd999_999,
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_INIT       = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic sel,
    output logic key_flag,
    output logic key_state
);

    localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
    localparam logic KEY_REL = KEY_ACTIVE_LOW;

    typedef enum logic [1:0] {IDLE, PRESS_FILT, PRESSED, REL_FILT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       key_sync;
    logic             key_s;
    logic             p;

    assign key_s = key_sync[1];
    assign p     = key_s ^ KEY_ACTIVE_LOW;

    // Reset loads the released level so a held key is seen as a fresh press afterwards.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) key_sync <= {2{KEY_REL}};
        else         key_sync <= {key_sync[0], key_in};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= SEL_INIT;
            key_flag  <= 1'b0;
            key_state <= 1'b0;
        end else begin
            key_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (p) begin
                        state <= PRESS_FILT;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (!p) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_TOP) begin
                        state     <= PRESSED;
                        cnt       <= '0;
                        key_flag  <= 1'b1;
                        sel       <= ~sel;
                        key_state <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!p) begin
                        state <= REL_FILT;
                        cnt   <= CNT_W'(1);
                    end
                end
                REL_FILT: begin
                    // A pressed sample here is release bounce: fall back without a new flag.
                    if (p) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_TOP) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        key_state <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    key_state <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_key_ctrl.sv
// Directed bench for mux_sel_key_ctrl with a short debounce window (CNT_MAX=4).
module tb_mux_sel_key_ctrl;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_in  = 1'b1;
    logic sel, key_flag, key_state;

    int errors = 0;
    int checks = 0;
    int flag_cnt = 0;
    int ks_cnt = 0;

    logic [7:0] in_1 = 8'hA5;
    logic [7:0] in_2 = 8'h3C;
    logic [7:0] mux_out;
    assign mux_out = sel ? in_2 : in_1;

    always #5 sys_clk = ~sys_clk;

    mux_sel_key_ctrl #(.CNT_MAX(4), .KEY_ACTIVE_LOW(1'b1), .SEL_INIT(1'b0)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key_in   (key_in),
        .sel      (sel),
        .key_flag (key_flag),
        .key_state(key_state)
    );

    // Drive key level for n edges, sampling 1 time unit after each edge.
    task automatic run(input int n, input logic k);
        key_in = k;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            if (key_flag === 1'b1) flag_cnt++;
            if (key_state === 1'b1) ks_cnt++;
        end
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        run(3, 1'b1);
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", sel); end
        checks++; if (key_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", key_flag); end
        checks++; if (key_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", key_state); end
        sys_rst = 1'b0;
        flag_cnt = 0; ks_cnt = 0;
        run(20, 1'b1);
        checks++; if (flag_cnt !== 0 || sel !== 1'b0 || ks_cnt !== 0) begin
            errors++; $display("FAIL reset_idle: flags=%0d sel=%b ks=%0d want 0/0/0", flag_cnt, sel, ks_cnt);
        end
    endtask

    task automatic test_clean_press;
        flag_cnt = 0;
        run(6, 1'b0);
        checks++; if (key_flag !== 1'b0 || sel !== 1'b0) begin
            errors++; $display("FAIL press_early: flag=%b sel=%b want 0/0 after edge 5", key_flag, sel);
        end
        run(1, 1'b0);
        checks++; if (key_flag !== 1'b1 || sel !== 1'b1 || key_state !== 1'b1) begin
            errors++; $display("FAIL press_edge6: flag=%b sel=%b ks=%b want 1/1/1", key_flag, sel, key_state);
        end
        run(1, 1'b0);
        checks++; if (key_flag !== 1'b0) begin errors++; $display("FAIL press_pulse: flag=%b want 0 after edge 7", key_flag); end
        run(12, 1'b0);
        checks++; if (flag_cnt !== 1 || sel !== 1'b1) begin
            errors++; $display("FAIL press_hold: flags=%0d sel=%b want 1/1", flag_cnt, sel);
        end
        flag_cnt = 0;
        run(6, 1'b1);
        checks++; if (key_state !== 1'b1) begin errors++; $display("FAIL release_early: ks=%b want 1 after edge 5", key_state); end
        run(1, 1'b1);
        checks++; if (key_state !== 1'b0) begin errors++; $display("FAIL release_edge6: ks=%b want 0", key_state); end
        run(13, 1'b1);
        checks++; if (flag_cnt !== 0 || sel !== 1'b1) begin
            errors++; $display("FAIL release_noflag: flags=%0d sel=%b want 0/1", flag_cnt, sel);
        end
    endtask

    task automatic test_bounce;
        flag_cnt = 0; ks_cnt = 0;
        run(3, 1'b0); run(1, 1'b1); run(3, 1'b0); run(10, 1'b1);
        checks++; if (flag_cnt !== 0 || sel !== 1'b1 || ks_cnt !== 0 || key_state !== 1'b0) begin
            errors++; $display("FAIL bounce: flags=%0d sel=%b ks_cycles=%0d want 0/1/0", flag_cnt, sel, ks_cnt);
        end
    endtask

    task automatic test_release_bounce;
        flag_cnt = 0;
        run(7, 1'b0);
        checks++; if (key_flag !== 1'b1 || sel !== 1'b0) begin
            errors++; $display("FAIL rb_press: flag=%b sel=%b want 1/0", key_flag, sel);
        end
        ks_cnt = 0;
        run(2, 1'b1); run(5, 1'b0);
        checks++; if (ks_cnt !== 7) begin errors++; $display("FAIL rb_hold: ks_cycles=%0d want 7", ks_cnt); end
        run(20, 1'b1);
        checks++; if (flag_cnt !== 1 || key_state !== 1'b0 || sel !== 1'b0) begin
            errors++; $display("FAIL rb_total: flags=%0d ks=%b sel=%b want 1/0/0", flag_cnt, key_state, sel);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_sel;
        exp_sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_sel = ~exp_sel;
            flag_cnt = 0;
            run(7, 1'b0);
            checks++; if (key_flag !== 1'b1 || sel !== exp_sel) begin
                errors++; $display("FAIL b2b_toggle%0d: flag=%b sel=%b want 1/%b", i, key_flag, sel, exp_sel);
            end
            checks++; if (mux_out !== (exp_sel ? 8'h3C : 8'hA5)) begin
                errors++; $display("FAIL b2b_mux%0d: out=%h want %h", i, mux_out, exp_sel ? 8'h3C : 8'hA5);
            end
            run(1, 1'b0);
            checks++; if (key_flag !== 1'b0) begin errors++; $display("FAIL b2b_pulse%0d: flag=%b want 0", i, key_flag); end
            run(12, 1'b0); run(10, 1'b1);
            checks++; if (flag_cnt !== 1 || sel !== exp_sel) begin
                errors++; $display("FAIL b2b_count%0d: flags=%0d sel=%b want 1/%b", i, flag_cnt, sel, exp_sel);
            end
        end
    endtask

    task automatic test_reset_mid_filter;
        flag_cnt = 0;
        run(5, 1'b0);
        sys_rst = 1'b1;
        run(2, 1'b0);
        checks++; if (flag_cnt !== 0 || sel !== 1'b0 || key_state !== 1'b0) begin
            errors++; $display("FAIL midrst_abort: flags=%0d sel=%b ks=%b want 0/0/0", flag_cnt, sel, key_state);
        end
        sys_rst = 1'b0;
        run(6, 1'b0);
        checks++; if (flag_cnt !== 0 || sel !== 1'b0) begin
            errors++; $display("FAIL midrst_early: flags=%0d sel=%b want 0/0", flag_cnt, sel);
        end
        run(1, 1'b0);
        checks++; if (key_flag !== 1'b1 || sel !== 1'b1) begin
            errors++; $display("FAIL midrst_confirm: flag=%b sel=%b want 1/1", key_flag, sel);
        end
        run(10, 1'b1);
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_release_bounce;
        test_back_to_back;
        test_reset_mid_filter;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
